// File: rtl/xbar_pkg.sv
// Shared types and sizing helpers for the configurable routing crossbar.
package xbar_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} cfg_state_e;

  localparam int ERR_COMMIT = 0;
  localparam int ERR_RANGE  = 1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int total_bits(input int n_out, input int sel_w);
    return n_out * sel_w;
  endfunction

  function automatic int n_words(input int total, input int cfg_w);
    return (total + cfg_w - 1) / cfg_w;
  endfunction

endpackage

// File: rtl/xbar_cfg_loader.sv
// Word-serial shadow loader: fills the select shadow one config word at a time
// and flags commit / bad-commit / out-of-range events for the active register.
//
//   state | meaning
//   IDLE  | no words held for the current load, ready for word 0
//   LOAD  | partial load in progress, count = next word index
//   FULL  | shadow complete, waiting for commit or abort
module xbar_cfg_loader
  import xbar_pkg::*;
#(
  parameter int N_IN  = 33,
  parameter int N_OUT = 40,
  parameter int SEL_W = clog2(N_IN),
  parameter int CFG_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CFG_W-1:0]       cfg_data,
  input  logic                   cfg_commit,
  input  logic                   cfg_abort,
  output logic                   cfg_loaded,
  output logic [N_OUT*SEL_W-1:0] shadow_sel,
  output logic                   commit_fire,
  output logic                   bad_commit,
  output logic                   range_bad
);

  localparam int TOTAL   = total_bits(N_OUT, SEL_W);
  localparam int N_WORDS = n_words(TOTAL, CFG_W);
  localparam int SH_W    = N_WORDS * CFG_W;
  localparam int CNT_W   = clog2(N_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(N_WORDS - 1);
  localparam logic [SEL_W:0]   N_IN_L = (SEL_W + 1)'(N_IN);

  cfg_state_e       state;
  logic [CNT_W-1:0] count;
  logic [SH_W-1:0]  shadow;
  logic             xfer;
  logic             any_bad;

  // Abort dominates everything that happens in the same cycle.
  assign xfer        = cfg_valid && cfg_ready && !cfg_abort;
  assign commit_fire = cfg_commit && !cfg_abort && (state == FULL);
  assign bad_commit  = cfg_commit && !cfg_abort && (state != FULL);
  assign range_bad   = commit_fire && any_bad;
  assign shadow_sel  = shadow[TOTAL-1:0];

  always_comb begin
    any_bad = 1'b0;
    for (int j = 0; j < N_OUT; j++) begin
      if ({1'b0, shadow[j*SEL_W +: SEL_W]} >= N_IN_L) any_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      shadow     <= '0;
      cfg_ready  <= 1'b1;
      cfg_loaded <= 1'b0;
    end else if (cfg_abort) begin
      state      <= IDLE;
      count      <= '0;
      cfg_ready  <= 1'b1;
      cfg_loaded <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (xfer) begin
            shadow[int'(count)*CFG_W +: CFG_W] <= cfg_data;
            count <= count + 1'b1;
            if (count == LAST) begin
              state      <= FULL;
              cfg_ready  <= 1'b0;
              cfg_loaded <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        FULL: begin
          if (cfg_commit) begin
            state      <= IDLE;
            count      <= '0;
            cfg_ready  <= 1'b1;
            cfg_loaded <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          count      <= '0;
          cfg_ready  <= 1'b1;
          cfg_loaded <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/xbar_cfg.sv
// Configurable routing crossbar: active select register loaded atomically from
// the shadow loader, per-output mux with range gating, sticky error flags.
module xbar_cfg
  import xbar_pkg::*;
#(
  parameter int N_IN    = 33,
  parameter int N_OUT   = 40,
  parameter int SEL_W   = clog2(N_IN),
  parameter int CFG_W   = 16,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  io_xbar_in,
  output logic [N_OUT-1:0] io_xbar_out,
  input  logic             io_cfg_valid,
  output logic             io_cfg_ready,
  input  logic [CFG_W-1:0] io_cfg_data,
  input  logic             io_cfg_commit,
  input  logic             io_cfg_abort,
  output logic             io_cfg_loaded,
  output logic             io_cfg_active,
  output logic [1:0]       io_err,
  input  logic             io_err_clr
);

  localparam int TOTAL = total_bits(N_OUT, SEL_W);
  localparam logic [SEL_W:0] N_IN_L = (SEL_W + 1)'(N_IN);

  logic [TOTAL-1:0] shadow_sel;
  logic [TOTAL-1:0] active_sel;
  logic             commit_fire;
  logic             bad_commit;
  logic             range_bad;
  logic [1:0]       err_set;
  logic [N_OUT-1:0] mux_out;
  logic [SEL_W-1:0] sel;

  xbar_cfg_loader #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .SEL_W (SEL_W),
    .CFG_W (CFG_W)
  ) u_loader (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (io_cfg_valid),
    .cfg_ready   (io_cfg_ready),
    .cfg_data    (io_cfg_data),
    .cfg_commit  (io_cfg_commit),
    .cfg_abort   (io_cfg_abort),
    .cfg_loaded  (io_cfg_loaded),
    .shadow_sel  (shadow_sel),
    .commit_fire (commit_fire),
    .bad_commit  (bad_commit),
    .range_bad   (range_bad)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_sel    <= '0;
      io_cfg_active <= 1'b0;
    end else if (commit_fire) begin
      active_sel    <= shadow_sel;
      io_cfg_active <= 1'b1;
    end
  end

  always_comb begin
    err_set             = 2'b00;
    err_set[ERR_COMMIT] = bad_commit;
    err_set[ERR_RANGE]  = range_bad;
  end

  // A fresh error in the clear cycle survives the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_err <= 2'b00;
    end else if (io_err_clr) begin
      io_err <= err_set;
    end else begin
      io_err <= io_err | err_set;
    end
  end

  always_comb begin
    mux_out = '0;
    sel     = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sel = active_sel[j*SEL_W +: SEL_W];
      if (io_cfg_active && ({1'b0, sel} < N_IN_L)) mux_out[j] = io_xbar_in[sel];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) io_xbar_out <= '0;
        else        io_xbar_out <= mux_out;
      end
    end else begin : g_out_comb
      assign io_xbar_out = mux_out;
    end
  endgenerate

endmodule

// File: tb/tb_xbar_cfg.sv
// Scoreboard bench for xbar_cfg: stimulus queues expected observable state,
// a negedge monitor pops and compares.
module tb_xbar_cfg;

  localparam int N_IN  = 33;
  localparam int N_OUT = 40;
  localparam int SEL_W = 6;
  localparam int CFG_W = 16;
  localparam int TOTAL = N_OUT * SEL_W;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_IN-1:0]  io_xbar_in;
  logic [N_OUT-1:0] io_xbar_out;
  logic             io_cfg_valid;
  logic             io_cfg_ready;
  logic [CFG_W-1:0] io_cfg_data;
  logic             io_cfg_commit;
  logic             io_cfg_abort;
  logic             io_cfg_loaded;
  logic             io_cfg_active;
  logic [1:0]       io_err;
  logic             io_err_clr;

  always #5 clk = ~clk;

  xbar_cfg #(
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .SEL_W   (SEL_W),
    .CFG_W   (CFG_W),
    .OUT_REG (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_xbar_in    (io_xbar_in),
    .io_xbar_out   (io_xbar_out),
    .io_cfg_valid  (io_cfg_valid),
    .io_cfg_ready  (io_cfg_ready),
    .io_cfg_data   (io_cfg_data),
    .io_cfg_commit (io_cfg_commit),
    .io_cfg_abort  (io_cfg_abort),
    .io_cfg_loaded (io_cfg_loaded),
    .io_cfg_active (io_cfg_active),
    .io_err        (io_err),
    .io_err_clr    (io_err_clr)
  );

  typedef struct packed {
    logic [N_OUT-1:0] out;
    logic             ready;
    logic             loaded;
    logic             active;
    logic [1:0]       err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  localparam logic [N_OUT-1:0] ALL1 = 40'hFF_FFFF_FFFF;

  task automatic exp_push(input string name, input logic [N_OUT-1:0] out,
                          input logic ready, input logic loaded,
                          input logic active, input logic [1:0] err);
    exp_t e;
    e.out = out; e.ready = ready; e.loaded = loaded; e.active = active; e.err = err;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t  e;
        exp_t  a;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {io_xbar_out, io_cfg_ready, io_cfg_loaded, io_cfg_active, io_err};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s: got out=%h ready=%b loaded=%b active=%b err=%b, want out=%h ready=%b loaded=%b active=%b err=%b",
                   n, a.out, a.ready, a.loaded, a.active, a.err,
                   e.out, e.ready, e.loaded, e.active, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // kind 0: identity (sel_j=j, j>=N_IN -> 0); 1: all sel=2; 2: identity with sel_0=40
  function automatic logic [TOTAL-1:0] make_cfg(input int kind);
    logic [TOTAL-1:0] c;
    int sel;
    c = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (kind == 1) sel = 2;
      else           sel = (j < N_IN) ? j : 0;
      if (kind == 2 && j == 0) sel = 40;
      c[j*SEL_W +: SEL_W] = sel[SEL_W-1:0];
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_words(input logic [TOTAL-1:0] cfg, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      io_cfg_valid = 1'b1;
      io_cfg_data  = cfg[k*CFG_W +: CFG_W];
      step();
    end
    io_cfg_valid = 1'b0;
  endtask

  task automatic commit_pulse();
    io_cfg_commit = 1'b1;
    step();
    io_cfg_commit = 1'b0;
  endtask

  task automatic check_in(input string name, input logic [N_IN-1:0] in_val,
                          input logic [N_OUT-1:0] out, input logic [1:0] err);
    io_xbar_in = in_val;
    step();
    exp_push(name, out, 1'b1, 1'b0, 1'b1, err);
  endtask

  logic [TOTAL-1:0] cfg_id, cfg_two, cfg_rng;

  initial begin
    cfg_id  = make_cfg(0);
    cfg_two = make_cfg(1);
    cfg_rng = make_cfg(2);
    reset = 1'b0;
    io_xbar_in = '0; io_cfg_valid = 1'b0; io_cfg_data = '0;
    io_cfg_commit = 1'b0; io_cfg_abort = 1'b0; io_err_clr = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    exp_push("reset", '0, 1'b1, 1'b0, 1'b0, 2'b00);

    io_xbar_in = 33'h1_FFFF_FFFF;
    step();
    exp_push("idle_no_cfg", '0, 1'b1, 1'b0, 1'b0, 2'b00);

    send_words(cfg_id, 0, 14);
    exp_push("load_14", '0, 1'b1, 1'b0, 1'b0, 2'b00);
    send_words(cfg_id, 14, 1);
    exp_push("load_15", '0, 1'b0, 1'b1, 1'b0, 2'b00);

    io_cfg_valid = 1'b1;
    io_cfg_data  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_push("backpressure", '0, 1'b0, 1'b1, 1'b0, 2'b00);
    end
    io_cfg_valid = 1'b0;

    io_xbar_in = 33'h0_0000_0005;
    commit_pulse();
    exp_push("commit_edge1", '0, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    exp_push("commit_edge2", 40'hFE_0000_0005, 1'b1, 1'b0, 1'b1, 2'b00);

    check_in("id_in_1_0001", 33'h1_0000_0001, 40'hFF_0000_0001, 2'b00);
    check_in("id_in_all1",   33'h1_FFFF_FFFF, ALL1,             2'b00);
    check_in("id_in_bit31",  33'h0_8000_0000, 40'h00_8000_0000, 2'b00);
    check_in("id_in_zero",   33'h0_0000_0000, 40'h00_0000_0000, 2'b00);
    check_in("id_in_4",      33'h0_0000_0004, 40'h00_0000_0004, 2'b00);

    send_words(cfg_two, 0, 7);
    exp_push("abort_pre", 40'h4, 1'b1, 1'b0, 1'b1, 2'b00);
    io_cfg_valid = 1'b1;
    io_cfg_data  = cfg_two[7*CFG_W +: CFG_W];
    io_cfg_abort = 1'b1;
    step();
    io_cfg_abort = 1'b0;
    io_cfg_valid = 1'b0;
    exp_push("abort", 40'h4, 1'b1, 1'b0, 1'b1, 2'b00);
    send_words(cfg_two, 0, 8);
    exp_push("reload_8", 40'h4, 1'b1, 1'b0, 1'b1, 2'b00);
    send_words(cfg_two, 8, 7);
    exp_push("reload_15", 40'h4, 1'b0, 1'b1, 1'b1, 2'b00);
    commit_pulse();
    exp_push("commit2_edge1", 40'h4, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    exp_push("commit2_edge2", ALL1, 1'b1, 1'b0, 1'b1, 2'b00);

    send_words(cfg_id, 0, 3);
    io_cfg_commit = 1'b1;
    io_cfg_valid  = 1'b1;
    io_cfg_data   = cfg_id[3*CFG_W +: CFG_W];
    step();
    io_cfg_commit = 1'b0;
    io_cfg_valid  = 1'b0;
    exp_push("bad_commit", ALL1, 1'b1, 1'b0, 1'b1, 2'b01);
    send_words(cfg_id, 4, 10);
    exp_push("after_bad_14", ALL1, 1'b1, 1'b0, 1'b1, 2'b01);
    send_words(cfg_id, 14, 1);
    exp_push("after_bad_15", ALL1, 1'b0, 1'b1, 1'b1, 2'b01);
    io_err_clr = 1'b1;
    step();
    io_err_clr = 1'b0;
    exp_push("err_clr", ALL1, 1'b0, 1'b1, 1'b1, 2'b00);
    io_cfg_abort = 1'b1;
    step();
    io_cfg_abort = 1'b0;
    exp_push("abort_full", ALL1, 1'b1, 1'b0, 1'b1, 2'b00);

    send_words(cfg_rng, 0, 15);
    io_xbar_in = 33'h1_FFFF_FFFF;
    commit_pulse();
    exp_push("range_edge1", ALL1, 1'b1, 1'b0, 1'b1, 2'b10);
    step();
    exp_push("range_edge2", 40'hFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 2'b10);
    check_in("range_in_1", 33'h0_0000_0001, 40'hFE_0000_0000, 2'b10);
    io_err_clr = 1'b1;
    step();
    io_err_clr = 1'b0;
    exp_push("range_clr", 40'hFE_0000_0000, 1'b1, 1'b0, 1'b1, 2'b00);

    send_words(cfg_two, 0, 15);
    exp_push("full_again", 40'hFE_0000_0000, 1'b0, 1'b1, 1'b1, 2'b00);
    io_cfg_commit = 1'b1;
    io_cfg_abort  = 1'b1;
    step();
    io_cfg_commit = 1'b0;
    io_cfg_abort  = 1'b0;
    exp_push("commit_abort", 40'hFE_0000_0000, 1'b1, 1'b0, 1'b1, 2'b00);
    step();
    exp_push("no_copy", 40'hFE_0000_0000, 1'b1, 1'b0, 1'b1, 2'b00);

    send_words(cfg_id, 0, 5);
    reset = 1'b0;
    #1;
    exp_push("reset_async", '0, 1'b1, 1'b0, 1'b0, 2'b00);
    step();
    reset = 1'b1;
    step();
    exp_push("post_reset", '0, 1'b1, 1'b0, 1'b0, 2'b00);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
